mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA), the arbiter and the unified Memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) ();

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_ack;

   logic [ADDR_W-1:0] Adress;
   logic [DATA_W-1:0] WriteData;
   logic              MemRead;
   logic              MemWrite;
   logic [DATA_W-1:0] MemData;
   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      input  MemData,
      output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
      output Adress, WriteData, MemRead, MemWrite, busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      output MemData,
      input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
      input  Adress, WriteData, MemRead, MemWrite, busy
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single unified memory: IDLE -> ACCESS -> RESP.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed CPU priority with a starvation guard.
module mem_port_arbiter #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int MEM_LATENCY = 1,
   parameter int STARVE_MAX  = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

   localparam int            LW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LATENCY - 1);

   stateT             state_q, state_d;
   logic [LW-1:0]     lat_q, lat_d;
   logic              we_q;
   logic              grantDma_q;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] cpuRdata_q;
   logic [DATA_W-1:0] dmaRdata_q;

   logic anyReq;
   logic pickDma;
   logic memReadOut, memWriteOut, cpuAckOut, dmaAckOut, busyOut;

   assign anyReq = bus.cpu_req | bus.dma_req;

`ifdef MEM_ARB_RR_EN
   logic lastDma_q;

   // On contention the port that did not win last time goes first.
   assign pickDma = bus.dma_req & (~bus.cpu_req | ~lastDma_q);
`else
   localparam int SW = $clog2(STARVE_MAX + 1);
   logic [SW-1:0] starve_q;

   assign pickDma = bus.dma_req & (~bus.cpu_req | (starve_q == SW'(STARVE_MAX)));
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      case (state_q)
         IDLE: begin
            if (anyReq) begin
               state_d = ACCESS;
               lat_d   = LAT_INIT;
            end
         end
         ACCESS: begin
            if (lat_q == '0) state_d = RESP;
            else             lat_d   = lat_q - 1'b1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Writes strobe only in the first ACCESS cycle; reads hold the strobe for the whole latency.
   always_comb begin
      memReadOut  = 1'b0;
      memWriteOut = 1'b0;
      cpuAckOut   = 1'b0;
      dmaAckOut   = 1'b0;
      busyOut     = 1'b0;
      case (state_q)
         ACCESS: begin
            busyOut     = 1'b1;
            memReadOut  = ~we_q;
            memWriteOut = we_q & (lat_q == LAT_INIT);
         end
         RESP: begin
            busyOut   = 1'b1;
            cpuAckOut = ~grantDma_q;
            dmaAckOut = grantDma_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q       <= 1'b0;
         grantDma_q <= 1'b0;
         adr_q      <= '0;
         wdata_q    <= '0;
         cpuRdata_q <= '0;
         dmaRdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         lastDma_q  <= 1'b1;
`else
         starve_q   <= '0;
`endif
      end else begin
         if (state_q == IDLE && anyReq) begin
            grantDma_q <= pickDma;
            we_q       <= pickDma ? bus.dma_we    : bus.cpu_we;
            adr_q      <= pickDma ? bus.dma_addr  : bus.cpu_addr;
            wdata_q    <= pickDma ? bus.dma_wdata : bus.cpu_wdata;
`ifdef MEM_ARB_RR_EN
            lastDma_q  <= pickDma;
`else
            if (pickDma || !bus.dma_req) starve_q <= '0;
            else                         starve_q <= starve_q + 1'b1;
`endif
         end
         if (state_q == ACCESS && lat_q == '0 && !we_q) begin
            if (grantDma_q) dmaRdata_q <= bus.MemData;
            else            cpuRdata_q <= bus.MemData;
         end
      end
   end

   assign bus.Adress    = adr_q;
   assign bus.WriteData = wdata_q;
   assign bus.MemRead   = memReadOut;
   assign bus.MemWrite  = memWriteOut;
   assign bus.cpu_ack   = cpuAckOut;
   assign bus.dma_ack   = dmaAckOut;
   assign bus.cpu_rdata = cpuRdata_q;
   assign bus.dma_rdata = dmaRdata_q;
   assign bus.busy      = busyOut;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: dutA runs MEM_LATENCY=1, dutB runs MEM_LATENCY=3.
// Expected acks (port + read data) are queued at issue time and popped by a negedge monitor.
module tb_mem_port_arbiter;

   typedef struct {
      bit          isDma;
      bit          isRead;
      logic [31:0] rdata;
   } expT;

   logic clk = 1'b0;
   logic rstA = 1'b1;
   logic rstB = 1'b1;
   int   cyc = 0;

   int   checks = 0;
   int   errors = 0;
   int   readCntA = 0, writeCntA = 0, readCntB = 0, overlapCnt = 0;
   logic [31:0] lastWAddrA = '0, lastWDataA = '0;
   expT  qA[$];
   expT  qB[$];

   mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) busA ();
   mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) busB ();

   mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(1), .STARVE_MAX(4)) dutA (
      .clk   (clk),
      .reset (rstA),
      .bus   (busA.slave)
   );

   mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(3), .STARVE_MAX(4)) dutB (
      .clk   (clk),
      .reset (rstB),
      .bus   (busB.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents: one fixed word at 0x10, every other address returns {addr[15:0], C0DE}.
   function automatic logic [31:0] memModel(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
   endfunction

   assign busA.MemData = memModel(busA.Adress);
   assign busB.MemData = memModel(busB.Adress);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic popAndCheck(input string tag, ref expT q[$], input logic cpuAck, input logic dmaAck,
                              input logic [31:0] cpuRd, input logic [31:0] dmaRd);
      expT e;
      if (q.size() == 0) begin
         checkOutput({tag, "_unexpectedAck"}, {30'd0, dmaAck, cpuAck}, 32'd0);
         return;
      end
      e = q.pop_front();
      checkOutput({tag, "_bothAcks"}, {31'd0, cpuAck & dmaAck}, 32'd0);
      checkOutput({tag, "_ackPort"}, {31'd0, dmaAck}, {31'd0, e.isDma});
      if (e.isRead)
         checkOutput({tag, "_rdata"}, e.isDma ? dmaRd : cpuRd, e.rdata);
   endtask

   task automatic scoreboardMonitor();
      forever begin
         @(negedge clk);
         if (busA.MemRead)  readCntA++;
         if (busB.MemRead)  readCntB++;
         if (busA.MemWrite) begin
            writeCntA++;
            lastWAddrA = busA.Adress;
            lastWDataA = busA.WriteData;
         end
         if ((busA.MemRead && busA.MemWrite) || (busB.MemRead && busB.MemWrite)) overlapCnt++;
         if (busA.cpu_ack || busA.dma_ack)
            popAndCheck("A", qA, busA.cpu_ack, busA.dma_ack, busA.cpu_rdata, busA.dma_rdata);
         if (busB.cpu_ack || busB.dma_ack)
            popAndCheck("B", qB, busB.cpu_ack, busB.dma_ack, busB.cpu_rdata, busB.dma_rdata);
      end
   endtask

   // One requester transaction on dutA; returns cycles from req assertion to the ack cycle (inclusive).
   task automatic applyStimulus(input bit isDma, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, output int lat);
      int  startCyc;
      bit  seen;
      seen = 1'b0;
      if (isDma) begin
         busA.dma_req = 1'b1; busA.dma_we = we; busA.dma_addr = addr; busA.dma_wdata = wdata;
      end else begin
         busA.cpu_req = 1'b1; busA.cpu_we = we; busA.cpu_addr = addr; busA.cpu_wdata = wdata;
      end
      startCyc = cyc;
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ((isDma && busA.dma_ack) || (!isDma && busA.cpu_ack)) begin
            seen = 1'b1;
            lat  = cyc - startCyc + 1;
            break;
         end
      end
      checkOutput(isDma ? "dmaAckSeen" : "cpuAckSeen", {31'd0, seen}, 32'd1);
      @(posedge clk);
      #1;
      if (isDma) busA.dma_req = 1'b0;
      else       busA.cpu_req = 1'b0;
   endtask

   initial begin
      int latC, latD, snapR, snapW, startCyc;
      bit seen;

      busA.cpu_req = 0; busA.cpu_we = 0; busA.cpu_addr = '0; busA.cpu_wdata = '0;
      busA.dma_req = 0; busA.dma_we = 0; busA.dma_addr = '0; busA.dma_wdata = '0;
      busB.cpu_req = 0; busB.cpu_we = 0; busB.cpu_addr = '0; busB.cpu_wdata = '0;
      busB.dma_req = 0; busB.dma_we = 0; busB.dma_addr = '0; busB.dma_wdata = '0;

      fork
         scoreboardMonitor();
      join_none

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_MemRead",   {31'd0, busA.MemRead},  32'd0);
      checkOutput("rst_MemWrite",  {31'd0, busA.MemWrite}, 32'd0);
      checkOutput("rst_busy",      {31'd0, busA.busy},     32'd0);
      checkOutput("rst_acks",      {30'd0, busA.dma_ack, busA.cpu_ack}, 32'd0);
      checkOutput("rst_Adress",    busA.Adress,    32'd0);
      checkOutput("rst_WriteData", busA.WriteData, 32'd0);
      checkOutput("rst_cpu_rdata", busA.cpu_rdata, 32'd0);
      checkOutput("rst_dma_rdata", busA.dma_rdata, 32'd0);
      checkOutput("rstB_busy",     {31'd0, busB.busy},     32'd0);
      @(posedge clk);
      #1;
      rstA = 1'b0;
      rstB = 1'b0;

      $display("[TB] Test 1: CPU read 0x10, latency 1");
      snapR = readCntA;
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'hDEADBEEF});
      applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, latC);
      checkOutput("t1_ackCycle", latC, 32'd3);
      checkOutput("t1_readCycles", readCntA - snapR, 32'd1);

      $display("[TB] Test 2: DMA write 0x40");
      snapW = writeCntA;
      snapR = readCntA;
      qA.push_back('{isDma: 1'b1, isRead: 1'b0, rdata: 32'h0});
      applyStimulus(1'b1, 1'b1, 32'h40, 32'h12345678, latD);
      checkOutput("t2_ackCycle", latD, 32'd3);
      checkOutput("t2_writeCycles", writeCntA - snapW, 32'd1);
      checkOutput("t2_readCycles", readCntA - snapR, 32'd0);
      checkOutput("t2_Adress", lastWAddrA, 32'h40);
      checkOutput("t2_WriteData", lastWDataA, 32'h12345678);

      $display("[TB] Test 3: simultaneous CPU and DMA reads");
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0020C0DE});
      qA.push_back('{isDma: 1'b1, isRead: 1'b1, rdata: 32'h0024C0DE});
      fork
         applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, latC);
         applyStimulus(1'b1, 1'b0, 32'h24, 32'h0, latD);
      join
      checkOutput("t3_cpuAckCycle", latC, 32'd3);
      checkOutput("t3_dmaAckCycle", latD, 32'd6);

      $display("[TB] Test 4: CPU back-to-back with DMA waiting");
`ifdef MEM_ARB_RR_EN
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0100C0DE});
      qA.push_back('{isDma: 1'b1, isRead: 1'b1, rdata: 32'h0200C0DE});
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0104C0DE});
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0108C0DE});
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h010CC0DE});
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0110C0DE});
`else
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0100C0DE});
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0104C0DE});
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0108C0DE});
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h010CC0DE});
      qA.push_back('{isDma: 1'b1, isRead: 1'b1, rdata: 32'h0200C0DE});
      qA.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0110C0DE});
`endif
      fork
         begin
            for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, latC);
         end
         applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, latD);
      join
`ifdef MEM_ARB_RR_EN
      checkOutput("t4_dmaAckCycle", latD, 32'd6);
`else
      checkOutput("t4_dmaAckCycle", latD, 32'd15);
`endif

      $display("[TB] Test 5: latency-3 read, address changed after grant");
      snapR = readCntB;
      qB.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0030C0DE});
      busB.cpu_req = 1'b1; busB.cpu_we = 1'b0; busB.cpu_addr = 32'h30;
      startCyc = cyc;
      @(posedge clk);
      #1;
      busB.cpu_addr = 32'h99;
      @(negedge clk);
      checkOutput("t5_AdressHeld", busB.Adress, 32'h30);
      checkOutput("t5_MemReadAccess", {31'd0, busB.MemRead}, 32'd1);
      seen = 1'b0;
      latC = 0;
      for (int i = 0; i < 20; i++) begin
         if (busB.cpu_ack) begin
            seen = 1'b1;
            latC = cyc - startCyc + 1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("t5_ackSeen", {31'd0, seen}, 32'd1);
      checkOutput("t5_ackCycle", latC, 32'd5);
      @(posedge clk);
      #1;
      busB.cpu_req = 1'b0;
      checkOutput("t5_readCycles", readCntB - snapR, 32'd3);

      $display("[TB] Test 6: reset in the second ACCESS cycle");
      @(posedge clk);
      #1;
      busB.cpu_req = 1'b1; busB.cpu_addr = 32'h50;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstB = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t6_MemReadAfterRst", {31'd0, busB.MemRead}, 32'd0);
      checkOutput("t6_busyAfterRst",    {31'd0, busB.busy},    32'd0);
      checkOutput("t6_AdressAfterRst",  busB.Adress,           32'd0);
      @(posedge clk);
      #1;
      rstB = 1'b0;
      qB.push_back('{isDma: 1'b0, isRead: 1'b1, rdata: 32'h0050C0DE});
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busB.cpu_ack) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("t6_freshAckSeen", {31'd0, seen}, 32'd1);
      @(posedge clk);
      #1;
      busB.cpu_req = 1'b0;

      for (int i = 0; i < 20 && (qA.size() != 0 || qB.size() != 0); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      checkOutput("queueA_drained", qA.size(), 32'd0);
      checkOutput("queueB_drained", qB.size(), 32'd0);
      checkOutput("readWriteOverlap", overlapCnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
